// File: rtl/scanner.sv
// Scan-and-shift block: counts a 4-bit sample up over 64 clocks, then shifts it out MSB first.
// Optional abort command enabled by defining SCANNER_ABORT_EN.
module scanner (
    input  logic       clk,
    input  logic       rst,
    input  logic       readyForTransferIn,
    input  logic [1:0] localTransferInput,
    output logic       clkOut,
    output logic       dataOut,
    output logic       commandDoneBit,
    output logic [2:0] dataBitCounter,
    output logic [2:0] slowCount,
    output logic [3:0] dataBuffer,
    output logic [1:0] ps
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        SCAN     = 2'b01,
        READY    = 2'b10,
        TRANSFER = 2'b11
    } state_e;

    localparam logic [1:0] CMD_START = 2'b01;
`ifdef SCANNER_ABORT_EN
    localparam logic [1:0] CMD_ABORT = 2'b10;
`endif

    state_e     ps_q, ps_d;
    logic [2:0] slow_q, slow_d;
    logic [3:0] buf_q, buf_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic       done_q, done_d;

    // Next-state and datapath update; abort overrides everything else
    always_comb begin
        ps_d     = ps_q;
        slow_d   = slow_q + 3'd1;
        buf_d    = buf_q;
        bitcnt_d = bitcnt_q;
        done_d   = 1'b0;
        unique case (ps_q)
            IDLE: begin
                if (localTransferInput == CMD_START) begin
                    ps_d   = SCAN;
                    slow_d = 3'd0;
                    buf_d  = 4'd0;
                end
            end
            SCAN: begin
                if (slow_q == 3'd7) begin
                    buf_d = buf_q + 4'd1;
                    if (buf_q == 4'd7) begin
                        ps_d = READY;
                    end
                end
            end
            READY: begin
                if (readyForTransferIn) begin
                    ps_d     = TRANSFER;
                    bitcnt_d = 3'd0;
                end
            end
            TRANSFER: begin
                buf_d    = {buf_q[2:0], 1'b0};
                bitcnt_d = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd3) begin
                    ps_d     = IDLE;
                    bitcnt_d = 3'd0;
                    done_d   = 1'b1;
                end
            end
        endcase
`ifdef SCANNER_ABORT_EN
        if ((ps_q != IDLE) && (localTransferInput == CMD_ABORT)) begin
            ps_d     = IDLE;
            slow_d   = slow_q + 3'd1;
            buf_d    = 4'd0;
            bitcnt_d = 3'd0;
            done_d   = 1'b0;
        end
`endif
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_q     <= IDLE;
            slow_q   <= 3'd0;
            buf_q    <= 4'd0;
            bitcnt_q <= 3'd0;
            done_q   <= 1'b0;
        end else begin
            ps_q     <= ps_d;
            slow_q   <= slow_d;
            buf_q    <= buf_d;
            bitcnt_q <= bitcnt_d;
            done_q   <= done_d;
        end
    end

    assign clkOut         = slow_q[2];
    assign dataOut        = (ps_q == TRANSFER) ? buf_q[3] : 1'b0;
    assign commandDoneBit = done_q;
    assign dataBitCounter = bitcnt_q;
    assign slowCount      = slow_q;
    assign dataBuffer     = buf_q;
    assign ps             = ps_q;

endmodule

// File: tb/tb_scanner.sv
// Directed self-checking bench for scanner.
// Covers reset, divider, full scan, ready hold, transfer, abort and async reset.
module tb_scanner;

    logic       clk;
    logic       rst;
    logic       ready;
    logic [1:0] cmd;
    logic       clk_out;
    logic       data_out;
    logic       done;
    logic [2:0] bitcnt;
    logic [2:0] slow;
    logic [3:0] dbuf;
    logic [1:0] ps;

    int total = 0;
    int bad   = 0;

    scanner dut (
        .clk                (clk),
        .rst                (rst),
        .readyForTransferIn (ready),
        .localTransferInput (cmd),
        .clkOut             (clk_out),
        .dataOut            (data_out),
        .commandDoneBit     (done),
        .dataBitCounter     (bitcnt),
        .slowCount          (slow),
        .dataBuffer         (dbuf),
        .ps                 (ps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".ps"}, 8'(ps), 8'd0);
        chk({tag, ".slow"}, 8'(slow), 8'd0);
        chk({tag, ".buf"}, 8'(dbuf), 8'd0);
        chk({tag, ".bitcnt"}, 8'(bitcnt), 8'd0);
        chk({tag, ".done"}, 8'(done), 8'd0);
        chk({tag, ".clkout"}, 8'(clk_out), 8'd0);
        chk({tag, ".dout"}, 8'(data_out), 8'd0);
    endtask

    task automatic run_scan(input logic noisy);
        logic [7:0] exp_slow;
        cmd = 2'b01;
        tick();
        cmd = 2'b00;
        chk("scan_entry.ps", 8'(ps), 8'h01);
        chk("scan_entry.slow", 8'(slow), 8'h00);
        chk("scan_entry.buf", 8'(dbuf), 8'h00);
        for (int k = 1; k <= 64; k++) begin
            ready = noisy && (k >= 10) && (k <= 20);
            cmd = 2'b00;
            if (noisy && k == 30) cmd = 2'b01;
            if (noisy && k == 40) cmd = 2'b11;
`ifndef SCANNER_ABORT_EN
            if (noisy && k == 50) cmd = 2'b10;
`endif
            tick();
            exp_slow = 8'(k % 8);
            chk($sformatf("scan%0d.slow", k), 8'(slow), exp_slow);
            chk($sformatf("scan%0d.buf", k), 8'(dbuf), 8'(k / 8));
            chk($sformatf("scan%0d.ps", k), 8'(ps), (k < 64) ? 8'h01 : 8'h02);
            chk($sformatf("scan%0d.done", k), 8'(done), 8'h00);
        end
        ready = 1'b0;
        cmd = 2'b00;
    endtask

    initial begin
        rst   = 1'b0;
        ready = 1'b0;
        cmd   = 2'b00;
        #12;
        chk_all_zero("reset");
        tick();
        chk_all_zero("reset_edge");
        rst = 1'b1;

        // Divider counts and wraps while idle; commands 11 and 10 ignored
        for (int i = 1; i <= 12; i++) begin
            cmd = (i == 3) ? 2'b11 : (i == 5) ? 2'b10 : 2'b00;
            tick();
            chk($sformatf("div%0d.slow", i), 8'(slow), 8'(i % 8));
            chk($sformatf("div%0d.clkout", i), 8'(clk_out), ((i % 8) >= 4) ? 8'd1 : 8'd0);
            chk($sformatf("div%0d.ps", i), 8'(ps), 8'h00);
            chk($sformatf("div%0d.buf", i), 8'(dbuf), 8'h00);
        end
        cmd = 2'b00;

        run_scan(1'b1);

        // Hold in READY without ready
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("hold%0d.ps", i), 8'(ps), 8'h02);
            chk($sformatf("hold%0d.buf", i), 8'(dbuf), 8'h08);
            chk($sformatf("hold%0d.dout", i), 8'(data_out), 8'h00);
            chk($sformatf("hold%0d.done", i), 8'(done), 8'h00);
        end

        // Transfer: 1,0,0,0 out, then done pulse
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("xfer0.ps", 8'(ps), 8'h03);
        chk("xfer0.buf", 8'(dbuf), 8'h08);
        chk("xfer0.bitcnt", 8'(bitcnt), 8'h00);
        chk("xfer0.dout", 8'(data_out), 8'h01);
        for (int j = 1; j <= 3; j++) begin
            tick();
            chk($sformatf("xfer%0d.ps", j), 8'(ps), 8'h03);
            chk($sformatf("xfer%0d.buf", j), 8'(dbuf), 8'h00);
            chk($sformatf("xfer%0d.bitcnt", j), 8'(bitcnt), 8'(j));
            chk($sformatf("xfer%0d.dout", j), 8'(data_out), 8'h00);
            chk($sformatf("xfer%0d.done", j), 8'(done), 8'h00);
        end
        tick();
        chk("xfer_end.ps", 8'(ps), 8'h00);
        chk("xfer_end.buf", 8'(dbuf), 8'h00);
        chk("xfer_end.bitcnt", 8'(bitcnt), 8'h00);
        chk("xfer_end.done", 8'(done), 8'h01);
        chk("xfer_end.dout", 8'(data_out), 8'h00);
        tick();
        chk("post_done.done", 8'(done), 8'h00);
        chk("post_done.ps", 8'(ps), 8'h00);

`ifdef SCANNER_ABORT_EN
        // Abort mid-scan returns to IDLE with a cleared buffer
        cmd = 2'b01;
        tick();
        cmd = 2'b00;
        for (int i = 0; i < 20; i++) tick();
        chk("abort_pre.buf", 8'(dbuf), 8'h02);
        cmd = 2'b10;
        tick();
        cmd = 2'b00;
        chk("abort.ps", 8'(ps), 8'h00);
        chk("abort.buf", 8'(dbuf), 8'h00);
        chk("abort.bitcnt", 8'(bitcnt), 8'h00);
        chk("abort.done", 8'(done), 8'h00);
        tick();
        chk("abort_next.done", 8'(done), 8'h00);
        chk("abort_next.ps", 8'(ps), 8'h00);
`endif

        // Async reset in the middle of a transfer
        run_scan(1'b0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        chk("mid_xfer.ps", 8'(ps), 8'h03);
        chk("mid_xfer.bitcnt", 8'(bitcnt), 8'h01);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        tick();
        chk_all_zero("async_rst_edge");
        rst = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("after_rst%0d.ps", i), 8'(ps), 8'h00);
            chk($sformatf("after_rst%0d.done", i), 8'(done), 8'h00);
            chk($sformatf("after_rst%0d.slow", i), 8'(slow), 8'(i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scanner.md
SCANNER -- requirements
Module: scanner

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port readyForTransferIn, input, 1 bit: downstream ready; starts a transfer from READY.
REQ-004 SHALL have port localTransferInput, input, 2 bits: command (00 none, 01 start scan, 10 abort, 11 reserved/ignored).
REQ-005 SHALL have port clkOut, output, 1 bit: divided clock, equal to slowCount[2].
REQ-006 SHALL have port dataOut, output, 1 bit: serial data, dataBuffer[3] in TRANSFER, else 0.
REQ-007 SHALL have port commandDoneBit, output, 1 bit: registered one-clk pulse after the last transfer bit.
REQ-008 SHALL have port dataBitCounter, output, 3 bits: count of bits already shifted in TRANSFER.
REQ-009 SHALL have port slowCount, output, 3 bits: clock-divider counter.
REQ-010 SHALL have port dataBuffer, output, 4 bits: scan sample buffer.
REQ-011 SHALL have port ps, output, 2 bits: present state (IDLE=00, SCAN=01, READY=10, TRANSFER=11).

Function
REQ-012 slowCount SHALL increment by 1 every clk and wrap 7->0, except it SHALL load 0 on the edge entering SCAN.
REQ-013 IDLE: localTransferInput==01 SHALL move to SCAN on the next edge with dataBuffer=0; other commands keep IDLE.
REQ-014 SCAN: on each edge with slowCount==7, dataBuffer SHALL increment by 1; the increment from 7 to 8 SHALL also move ps to READY (64 clk after SCAN entry).
REQ-015 SCAN: readyForTransferIn and command 01 SHALL be ignored.
REQ-016 READY: dataBuffer SHALL hold; readyForTransferIn==1 on an edge SHALL move to TRANSFER with dataBitCounter=0.
REQ-017 TRANSFER: each edge SHALL shift dataBuffer left by 1 (0 fill) and increment dataBitCounter; MSB goes out first on dataOut.
REQ-018 TRANSFER: the edge with dataBitCounter==3 SHALL move to IDLE, set dataBitCounter=0, and set commandDoneBit=1 for exactly one clk.
REQ-019 commandDoneBit SHALL be 0 in all other cycles.
REQ-020 Command 11 SHALL be ignored in every state.
REQ-021 Abort (when compiled in, REQ-026) SHALL take priority over all other transitions on the same edge.

Reset
REQ-022 rst low SHALL immediately force ps=IDLE, slowCount=0, dataBuffer=0, dataBitCounter=0, commandDoneBit=0.
REQ-023 Outputs SHALL be clkOut=0 and dataOut=0 while in reset.
REQ-024 Reset asserted mid-SCAN or mid-TRANSFER SHALL discard all progress; no done pulse is produced.
REQ-025 After rst rises, the block SHALL wait in IDLE for a command.

Configuration
REQ-026 Macro SCANNER_ABORT_EN: when defined, command 10 in any non-IDLE state SHALL return to IDLE on the next edge with dataBuffer=0, dataBitCounter=0 and no done pulse. When undefined, command 10 SHALL be ignored like 00.

Verification
REQ-027 Reset then release -> ps=00, dataBuffer=0000, slowCount counts 0..7 and wraps, clkOut high while slowCount is 4..7.
REQ-028 Command 01 in IDLE -> ps=01, dataBuffer steps 1..8 every 8 clk, ps=10 exactly 64 clk after SCAN entry with dataBuffer=1000.
REQ-029 In READY, hold 16 clk without ready -> ps stays 10, dataBuffer=1000, dataOut=0.
REQ-030 readyForTransferIn=1 in READY -> ps=11; dataOut 1,0,0,0 over 4 clk; dataBitCounter 0..3; then ps=00, dataBuffer=0000, commandDoneBit high for exactly 1 clk.
REQ-031 With SCANNER_ABORT_EN defined, command 10 mid-SCAN -> ps=00 and dataBuffer=0 next edge, no done pulse. Without the macro -> scan continues unaffected.
REQ-032 rst low mid-TRANSFER -> all outputs 0 immediately, without waiting for a clock edge.
